// File: rtl/reset_sequencer_if.sv
// Reset sequencer request/response bundle.
// Carries the external and software reset requests into the sequencer and
// the per-channel resets, release flag and reset cause back out.
//   i_rst_req_n     external reset request, asynchronous, active-low
//   i_sw_rst        software reset pulse, synchronous, active-high
//   o_rst_n         per-channel reset, active-low
//   o_all_released  every channel released
//   o_rst_cause     cause of the most recent hold entry
// master: the requester side. slave: the sequencer.
interface reset_sequencer_if #(
  parameter int unsigned NUM_CH = 4
);

  logic              i_rst_req_n;
  logic              i_sw_rst;
  logic [NUM_CH-1:0] o_rst_n;
  logic              o_all_released;
  logic [1:0]        o_rst_cause;

  modport master (
    output i_rst_req_n,
    output i_sw_rst,
    input  o_rst_n,
    input  o_all_released,
    input  o_rst_cause
  );

  modport slave (
    input  i_rst_req_n,
    input  i_sw_rst,
    output o_rst_n,
    output o_all_released,
    output o_rst_cause
  );

endinterface

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer.
// Merges a global synchronous reset, a synchronised and glitch-filtered
// external reset pin and a software reset pulse. All channels assert
// together, stay asserted for a minimum hold time once requests clear, then
// release one by one in channel order with a fixed stagger.
// Ports:
//   clk    single rising-edge clock
//   i_rst  global reset, synchronous, active-high, top priority
//   bus    reset_sequencer_if.slave (requests in; o_rst_n, o_all_released,
//          o_rst_cause out, all registered)
module reset_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  reset_sequencer_if.slave bus
);

  localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned STG_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FILTER_CYCLES);
  localparam logic [FILT_W-1:0] FILT_PRE  = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

  localparam logic [1:0] CAUSE_RST = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      filt_cnt_q;
  logic                   ext_req_q;
  logic                   sync_low;
  logic                   req_c;

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [STG_W-1:0]  stg_cnt_q,  stg_cnt_d;
  logic [CH_W-1:0]   ch_idx_q,   ch_idx_d;

  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              all_rel_q, all_rel_d;
  logic [1:0]        cause_q, cause_d;

  // External pin: synchroniser chain; reset value is the deasserted level.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_rst_req_n};
    end
  end

  assign sync_low = ~sync_q[SYNC_STAGES-1];

  // Glitch filter: a request is accepted only after FILTER_CYCLES
  // consecutive synchronised-low samples; ext_req goes high on the same
  // edge the count saturates.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      filt_cnt_q <= '0;
      ext_req_q  <= 1'b0;
    end else if (sync_low) begin
      if (filt_cnt_q != FILT_MAX) begin
        filt_cnt_q <= filt_cnt_q + FILT_W'(1);
      end
      ext_req_q <= (filt_cnt_q == FILT_PRE) || (filt_cnt_q == FILT_MAX);
    end else begin
      filt_cnt_q <= '0;
      ext_req_q  <= 1'b0;
    end
  end

  assign req_c = ext_req_q | bus.i_sw_rst;

  // State register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    ch_idx_d   = ch_idx_q;

    case (state_q)
      ST_HOLD: begin
        if (req_c) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          stg_cnt_d  = '0;
          ch_idx_d   = CH_W'(1);
          state_d    = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_RELEASE: begin
        if (req_c) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          stg_cnt_d  = '0;
          ch_idx_d   = '0;
        end else if (stg_cnt_q == STG_LAST) begin
          stg_cnt_d = '0;
          if (ch_idx_q == CH_LAST) begin
            state_d = ST_RUN;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
          end
        end else begin
          stg_cnt_d = stg_cnt_q + STG_W'(1);
        end
      end

      ST_RUN: begin
        if (req_c) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          stg_cnt_d  = '0;
          ch_idx_d   = '0;
        end
      end

      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        stg_cnt_d  = '0;
        ch_idx_d   = '0;
      end
    endcase
  end

  // Output next values; channels are released by OR-ing in the next bit so
  // the released set is always a prefix.
  always_comb begin
    rst_n_d   = rst_n_q;
    all_rel_d = all_rel_q;
    cause_d   = cause_q;

    if (req_c) begin
      cause_d = ext_req_q ? CAUSE_EXT : CAUSE_SW;
    end

    case (state_d)
      ST_HOLD: begin
        rst_n_d   = '0;
        all_rel_d = 1'b0;
      end

      ST_RELEASE: begin
        all_rel_d = 1'b0;
        if (state_q == ST_HOLD) begin
          rst_n_d = NUM_CH'(1);
        end else if (stg_cnt_q == STG_LAST) begin
          rst_n_d = rst_n_q | (NUM_CH'(1) << ch_idx_q);
        end
      end

      ST_RUN: begin
        rst_n_d   = '1;
        all_rel_d = 1'b1;
      end

      default: begin
        rst_n_d   = '0;
        all_rel_d = 1'b0;
      end
    endcase
  end

  // Counter and output registers; i_rst overrides everything.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      ch_idx_q   <= '0;
      rst_n_q    <= '0;
      all_rel_q  <= 1'b0;
      cause_q    <= CAUSE_RST;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      ch_idx_q   <= ch_idx_d;
      rst_n_q    <= rst_n_d;
      all_rel_q  <= all_rel_d;
      cause_q    <= cause_d;
    end
  end

  assign bus.o_rst_n        = rst_n_q;
  assign bus.o_all_released = all_rel_q;
  assign bus.o_rst_cause    = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios plus randomized request
// traffic, checked cycle by cycle against a behavioural model through an
// expected-value queue.
module tb_reset_sequencer;

  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned FILTER_CYCLES  = 4;
  localparam int unsigned HOLD_CYCLES    = 16;
  localparam int unsigned STAGGER_CYCLES = 8;
  localparam int          MAXE           = 16384;

  logic clk = 1'b0;
  logic i_rst;

  reset_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

  reset_sequencer #(
    .NUM_CH         (NUM_CH),
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_CYCLES  (FILTER_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STAGGER_CYCLES (STAGGER_CYCLES)
  ) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] rst_n;
    logic              all_rel;
    logic [1:0]        cause;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Model: k = req-free edges since the last edge that saw a request or
  // i_rst; released channel count follows from k by arithmetic.
  int       edge_no = 0;
  int       k       = 0;
  int       m_n     = 0;
  bit       m_ext   = 1'b0;
  bit [1:0] m_cause = 2'b00;
  bit       pin_hist [0:MAXE-1];

  function automatic bit pin_eff(int e);
    if (e < 1) return 1'b1;
    return pin_hist[e];
  endfunction

  function automatic int released(int kk);
    int n;
    if (kk < int'(HOLD_CYCLES)) return 0;
    n = 1 + (kk - int'(HOLD_CYCLES)) / int'(STAGGER_CYCLES);
    return (n > int'(NUM_CH)) ? int'(NUM_CH) : n;
  endfunction

  // Drive one edge's inputs and queue the expected outputs after that edge.
  task automatic step(input bit rst, input bit pin, input bit sw);
    exp_t e;
    @(negedge clk);
    i_rst           = rst;
    bus.i_rst_req_n = pin;
    bus.i_sw_rst    = sw;
    if (edge_no < MAXE - 1) edge_no++;
    pin_hist[edge_no] = pin;
    if (rst) begin
      k       = 0;
      m_cause = 2'b00;
      m_ext   = 1'b0;
      // Sync reset means the last SYNC_STAGES pin samples read as high.
      for (int j = 0; j < int'(SYNC_STAGES); j++)
        if (edge_no - j >= 1) pin_hist[edge_no - j] = 1'b1;
    end else begin
      if (m_ext || sw) begin
        k       = 0;
        m_cause = m_ext ? 2'b01 : 2'b10;
      end else begin
        k++;
      end
      // Accepted once the pin was low on FILTER_CYCLES samples, SYNC_STAGES late.
      m_ext = 1'b1;
      for (int j = 0; j < int'(FILTER_CYCLES); j++)
        if (pin_eff(edge_no - int'(SYNC_STAGES) - j)) m_ext = 1'b0;
    end
    m_n = released(k);
    for (int i = 0; i < int'(NUM_CH); i++) e.rst_n[i] = (i < m_n);
    e.all_rel = (m_n == int'(NUM_CH));
    e.cause   = m_cause;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic pin_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_until(input int target, input int limit);
    int c = 0;
    while (m_n != target && c < limit) begin
      step(1'b0, 1'b1, 1'b0);
      c++;
    end
  endtask

  task automatic check(input string name, input int mon_edge, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, mon_edge, got, want);
    end
  endtask

  // Monitor: compare each registered output set against the queued model.
  initial begin : monitor
    exp_t e;
    int   mon_edge = 0;
    logic [NUM_CH-1:0] r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        mon_edge++;
        r = bus.o_rst_n;
        check("o_rst_n", mon_edge, int'(r), int'(e.rst_n));
        check("o_all_released", mon_edge, int'(bus.o_all_released), int'(e.all_rel));
        check("o_rst_cause", mon_edge, int'(bus.o_rst_cause), int'(e.cause));
        check("prefix", mon_edge, int'(r & (r + NUM_CH'(1))), 0);
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    i_rst           = 1'b1;
    bus.i_rst_req_n = 1'b1;
    bus.i_sw_rst    = 1'b0;
    for (int i = 0; i < MAXE; i++) pin_hist[i] = 1'b1;

    // Power-on: i_rst for 3 cycles then full release sequence.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    idle(45);

    // Filtered external request from RUN, then re-release.
    pin_low(10);
    idle(50);

    // Short pin glitch: must be ignored.
    pin_low(3);
    idle(20);

    // Software reset during RELEASE with two channels released.
    step(1'b0, 1'b1, 1'b1);
    idle_until(2, 100);
    step(1'b0, 1'b1, 1'b1);

    // Software reset in HOLD after 10 quiet cycles restarts the hold time.
    idle(10);
    step(1'b0, 1'b1, 1'b1);
    idle(50);

    // Software and filtered external request on the same edge.
    pin_low(6);
    step(1'b0, 1'b0, 1'b1);
    pin_low(2);
    idle(50);

    // Global reset mid-RELEASE.
    step(1'b0, 1'b1, 1'b1);
    idle_until(2, 100);
    step(1'b1, 1'b1, 1'b0);
    idle(50);

    // Randomized traffic.
    for (int b = 0; b < 150; b++) begin
      int lo   = $urandom_range(0, 9);
      int quiet = $urandom_range(0, 60);
      for (int i = 0; i < lo; i++)
        step(($urandom_range(0, 511) == 0), 1'b0, ($urandom_range(0, 15) == 0));
      for (int i = 0; i < quiet; i++)
        step(($urandom_range(0, 511) == 0), 1'b1, ($urandom_range(0, 63) == 0));
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
